microcode_sequencer: RTL and testbench
======================================

// Module: microcode_sequencer
// PURPOSE
//   Control-logic state that forms the 12-bit microcode address ADDR = {cond_var, opcode, microop_count}.
//   Holds the opcode register, the micro-op counter and the latched condition bit.
//   Consumes the decoded control-word fields of the previous micro-op.
//   Sits directly upstream of the microcode LUT and closes the fetch/execute loop.
// PARAMETERS
//   OPCODE_W     6  opcode register width (ADDR[10:5])
//   COUNT_W      5  micro-op counter width (ADDR[4:0])
//   IN_OPCODE    6  in_plane code that loads the opcode register
//   RESET_OP     0  opcode entered on reset, boot hold and counter overflow
// PORTS
//   CLK            in   1   system clock; all state updates on rising edge
//   N_RST          in   1   asynchronous active-low reset
//   N_BOOTED       in   1   high = bootstrap in progress; sequencer held
//   IN_PLANE       in   3   control word OUT[14:12]
//   MISC_PLANE     in   1   control word OUT[15]; 1 = reset micro-op counter
//   OPCODE_SEL     in   1   control word OUT[23]; 0 = opword opcode, 1 = BUS[5:0]
//   COND_VAR_SEL   in   2   control word OUT[25:24]; 0 zero, 1 carry, 2 negative, 3 interrupt
//   BUS            in   32  shared data bus
//   OPWORD_OPCODE  in   6   opword register bits [31:26]
//   MLU_ZERO, MLU_CARRY, MLU_NEGATIVE  in  1 each  MLU flags for the current cycle
//   INTERRUPT      in   1   external interrupt request
//   ADDR           out  12  microcode address {cond_var, opcode, count}
//   OVERFLOW       out  1   sticky; counter ran past its maximum
// BEHAVIOUR
//   - Reset (N_RST low, async): opcode=RESET_OP, count=0, cond_var=0, OVERFLOW=0, so ADDR=0.
//   - ADDR comes straight from the registers with zero combinational logic. The micro-op is valid for the whole cycle.
//   - Boot hold (N_BOOTED=1, sync): same values as reset, except OVERFLOW is held. This has top priority over all rules below.
//   - Counter: MISC_PLANE=1 -> count<=0; otherwise count<=count+1.
//   - Counter overflow: count==2^COUNT_W-1 with MISC_PLANE=0 -> count<=0, opcode<=RESET_OP, OVERFLOW<=1.
//     Overflow overrides any opcode load in that cycle. OVERFLOW clears only on N_RST.
//   - Opcode load: IN_PLANE==IN_OPCODE -> opcode <= OPCODE_SEL ? BUS[5:0] : OPWORD_OPCODE.
//     Other IN_PLANE values leave the opcode unchanged.
//   - Simultaneous load + MISC_PLANE=1 (GO_FETCH, fetch step 4): next ADDR = {cond, new opcode, 0}.
//   - Load with MISC_PLANE=0: the new opcode continues at count+1.
//   - cond_var: latched every cycle from the source chosen by COND_VAR_SEL. The flags of cycle N drive ADDR[11] in cycle N+1.
//     The default sel=0 tracks MLU_ZERO continuously.
//   - Count width is exact with no carry-out to the opcode; the opcode is never incremented.
//   - Reset asserted mid-instruction aborts immediately. Release restarts at ADDR=0 (rst micro-program).
// CONFIGURATION
//   MICROCODE_SEQ_IRQ_SYNC_EN defined:
//     - INTERRUPT passes through a 2-flop synchroniser, reset to 0, before the cond mux.
//     - Interrupt-to-ADDR[11] latency is 3 cycles.
//   Not defined:
//     - INTERRUPT feeds the cond mux directly, with 1-cycle latency.
//     - INTERRUPT must then be synchronous to CLK.
// TESTING
//   1. Reset: N_RST low, then release with N_BOOTED=0 and IN_PLANE=0, MISC_PLANE=0 -> ADDR 0x000 then 0x001 on successive edges.
//   2. Fetch path:
//      - Cycle 1: IN_PLANE=6, OPCODE_SEL=1, BUS=0x1, MISC_PLANE=1 -> ADDR=0x020.
//      - Later: IN_PLANE=6, OPCODE_SEL=0, OPWORD_OPCODE=8, MISC_PLANE=1 -> ADDR=0x100.
//   3. Condition branch: in opcode 8 (BEQ), drive MLU_ZERO=1 with COND_VAR_SEL=0 at count 2 -> next ADDR=0x903.
//      Repeat with MLU_ZERO=0 -> next ADDR=0x103.
//   4. Overflow: opcode 3, run 31 cycles with MISC_PLANE=0 -> ADDR reaches 0x07F, then 0x000 with OVERFLOW=1.
//      OVERFLOW stays 1 until N_RST.
//   5. Boot hold: N_BOOTED=1 while mid-instruction at ADDR=0x104 -> ADDR=0x000 on the next edge and held.
//      Release -> 0x001.
//   6. IRQ: COND_VAR_SEL=3, INTERRUPT rises -> ADDR[11]=1 after 1 cycle.
//      With MICROCODE_SEQ_IRQ_SYNC_EN defined, after 3 cycles.

Source files
------------

// File: rtl/microcode_sequencer.sv
// Sequencer state behind the microcode address {cond_var, opcode, count}.
// Optional MICROCODE_SEQ_IRQ_SYNC_EN adds a 2-flop synchroniser on interrupt_i ahead of the cond mux.
module microcode_sequencer #(
    parameter int                  OPCODE_W  = 6,
    parameter int                  COUNT_W   = 5,
    parameter logic [2:0]          IN_OPCODE = 3'd6,
    parameter logic [OPCODE_W-1:0] RESET_OP  = '0
) (
    input  logic                          clk_i,
    input  logic                          n_rst_i,
    input  logic                          n_booted_i,
    input  logic [2:0]                    in_plane_i,
    input  logic                          misc_plane_i,
    input  logic                          opcode_sel_i,
    input  logic [1:0]                    cond_var_sel_i,
    input  logic [31:0]                   bus_i,
    input  logic [OPCODE_W-1:0]           opword_opcode_i,
    input  logic                          mlu_zero_i,
    input  logic                          mlu_carry_i,
    input  logic                          mlu_negative_i,
    input  logic                          interrupt_i,
    output logic [OPCODE_W+COUNT_W:0]     addr_o,
    output logic                          overflow_o
);

    localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                cond_q, cond_d;
    logic                overflow_q, overflow_d;
    logic                irq_src;
    logic                cond_src;

    // Only the low bus bits carry an opcode; the rest are intentionally ignored.
    logic unused_bus;
    assign unused_bus = ^bus_i[31:OPCODE_W];

`ifdef MICROCODE_SEQ_IRQ_SYNC_EN
    logic irq_meta_q, irq_sync_q;

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            irq_meta_q <= 1'b0;
            irq_sync_q <= 1'b0;
        end else begin
            irq_meta_q <= interrupt_i;
            irq_sync_q <= irq_meta_q;
        end
    end

    assign irq_src = irq_sync_q;
`else
    assign irq_src = interrupt_i;
`endif

    always_comb begin
        cond_src = mlu_zero_i;
        case (cond_var_sel_i)
            2'd0:    cond_src = mlu_zero_i;
            2'd1:    cond_src = mlu_carry_i;
            2'd2:    cond_src = mlu_negative_i;
            default: cond_src = irq_src;
        endcase
    end

    always_comb begin
        opcode_d   = opcode_q;
        count_d    = count_q;
        cond_d     = cond_src;
        overflow_d = overflow_q;
        if (n_booted_i) begin
            opcode_d = RESET_OP;
            count_d  = '0;
            cond_d   = 1'b0;
        end else begin
            if (in_plane_i == IN_OPCODE) begin
                opcode_d = opcode_sel_i ? bus_i[OPCODE_W-1:0] : opword_opcode_i;
            end
            if (misc_plane_i) begin
                count_d = '0;
            end else if (count_q == {COUNT_W{1'b1}}) begin
                // Running off the end of a micro-program: fall back to the reset routine.
                count_d    = '0;
                opcode_d   = RESET_OP;
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + COUNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            opcode_q   <= RESET_OP;
            count_q    <= '0;
            cond_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            opcode_q   <= opcode_d;
            count_q    <= count_d;
            cond_q     <= cond_d;
            overflow_q <= overflow_d;
        end
    end

    assign addr_o     = {cond_q, opcode_q, count_q};
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_microcode_sequencer.sv
// Randomised and directed bench for microcode_sequencer against an arithmetic address model.
module tb_microcode_sequencer;

`ifdef MICROCODE_SEQ_IRQ_SYNC_EN
    localparam int IRQ_LAT = 3;
`else
    localparam int IRQ_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        n_rst;
    logic        n_booted;
    logic [2:0]  in_plane;
    logic        misc_plane;
    logic        opcode_sel;
    logic [1:0]  cond_var_sel;
    logic [31:0] bus;
    logic [5:0]  opword_opcode;
    logic        mlu_zero, mlu_carry, mlu_negative;
    logic        interrupt;
    logic [11:0] addr;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Model state as plain integers
    int m_op, m_cnt, m_cond, m_ovf;
    int irq_hist1, irq_hist2;

    always #5 clk = ~clk;

    microcode_sequencer dut (
        .clk_i           (clk),
        .n_rst_i         (n_rst),
        .n_booted_i      (n_booted),
        .in_plane_i      (in_plane),
        .misc_plane_i    (misc_plane),
        .opcode_sel_i    (opcode_sel),
        .cond_var_sel_i  (cond_var_sel),
        .bus_i           (bus),
        .opword_opcode_i (opword_opcode),
        .mlu_zero_i      (mlu_zero),
        .mlu_carry_i     (mlu_carry),
        .mlu_negative_i  (mlu_negative),
        .interrupt_i     (interrupt),
        .addr_o          (addr),
        .overflow_o      (overflow)
    );

    function automatic int model_addr();
        return m_cond * 2048 + m_op * 32 + m_cnt;
    endfunction

    task automatic model_reset();
        m_op = 0; m_cnt = 0; m_cond = 0; m_ovf = 0;
        irq_hist1 = 0; irq_hist2 = 0;
    endtask

    // Applies the sequencing rules to the inputs present at this clock edge.
    task automatic model_edge();
        int src, irq_seen;
        if (!n_rst) begin
            model_reset();
            return;
        end
        irq_seen = (IRQ_LAT == 3) ? irq_hist2 : int'(interrupt);
        case (cond_var_sel)
            2'd0:    src = int'(mlu_zero);
            2'd1:    src = int'(mlu_carry);
            2'd2:    src = int'(mlu_negative);
            default: src = irq_seen;
        endcase
        if (n_booted) begin
            m_op = 0; m_cnt = 0; m_cond = 0;
        end else begin
            m_cond = src;
            if (in_plane == 3'd6) m_op = opcode_sel ? int'(bus % 64) : int'(opword_opcode);
            if (misc_plane) m_cnt = 0;
            else if (m_cnt + 1 >= 32) begin
                m_cnt = 0; m_op = 0; m_ovf = 1;
            end else m_cnt = m_cnt + 1;
        end
        irq_hist2 = irq_hist1;
        irq_hist1 = int'(interrupt);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%03h expected 0x%03h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_plane = 3'd0; misc_plane = 1'b0; opcode_sel = 1'b0; cond_var_sel = 2'd0;
        bus = 32'd0; opword_opcode = 6'd0; mlu_zero = 1'b0; mlu_carry = 1'b0;
        mlu_negative = 1'b0; interrupt = 1'b0; n_booted = 1'b0;
    endtask

    task automatic go_fetch(input bit from_bus, input int op);
        in_plane = 3'd6; misc_plane = 1'b1; opcode_sel = from_bus;
        bus = 32'(op); opword_opcode = 6'(op);
        cyc();
        in_plane = 3'd0; misc_plane = 1'b0;
    endtask

    // Single compare process: DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            n_checks++;
            if (int'(addr) != model_addr() || int'(overflow) != m_ovf) begin
                n_fail++;
                $display("FAIL cycle_cmp @%0t: got addr=0x%03h ovf=%0d expected addr=0x%03h ovf=%0d",
                         $time, addr, overflow, model_addr(), m_ovf);
            end
        end
    end

    initial begin
        int waited;
        idle_inputs();
        n_rst = 1'b0;
        model_reset();
        cmp_en = 1'b1;

        // Reset then release
        cyc(); cyc();
        chk("reset_addr", int'(addr), 0);
        chk("reset_ovf", int'(overflow), 0);
        n_rst = 1'b1;
        #1;
        chk("release_addr", int'(addr), 0);
        cyc();
        chk("first_step", int'(addr), 12'h001);

        // Fetch path
        go_fetch(1'b1, 1);
        chk("fetch_bus", int'(addr), 12'h020);
        go_fetch(1'b0, 8);
        chk("fetch_opword", int'(addr), 12'h100);

        // Condition branch in opcode 8
        cyc(); cyc();
        chk("beq_count2", int'(addr), 12'h102);
        mlu_zero = 1'b1;
        cyc();
        chk("beq_taken", int'(addr), 12'h903);
        mlu_zero = 1'b0;
        go_fetch(1'b0, 8);
        cyc(); cyc(); cyc();
        chk("beq_not_taken", int'(addr), 12'h103);

        // Counter overflow from opcode 3
        go_fetch(1'b1, 3);
        chk("op3_start", int'(addr), 12'h060);
        repeat (31) cyc();
        chk("op3_end", int'(addr), 12'h07F);
        chk("ovf_before", int'(overflow), 0);
        in_plane = 3'd6; opcode_sel = 1'b1; bus = 32'd9;  // load loses to overflow
        cyc();
        in_plane = 3'd0;
        chk("ovf_wrap_addr", int'(addr), 12'h000);
        chk("ovf_set", int'(overflow), 1);

        // Boot hold mid-instruction
        go_fetch(1'b0, 8);
        repeat (4) cyc();
        chk("boot_pre", int'(addr), 12'h104);
        n_booted = 1'b1; mlu_zero = 1'b1;
        cyc();
        chk("boot_hold1", int'(addr), 12'h000);
        cyc();
        chk("boot_hold2", int'(addr), 12'h000);
        n_booted = 1'b0; mlu_zero = 1'b0;
        cyc();
        chk("boot_release", int'(addr), 12'h001);
        chk("ovf_sticky", int'(overflow), 1);

        // Interrupt latency to ADDR[11]
        cond_var_sel = 2'd3;
        cyc(); cyc(); cyc();
        interrupt = 1'b1;
        waited = 0;
        while (addr[11] !== 1'b1 && waited < 8) begin
            cyc();
            waited++;
        end
        chk("irq_latency", waited, IRQ_LAT);
        idle_inputs();
        cyc(); cyc(); cyc();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            in_plane      = ($urandom_range(0, 3) == 0) ? 3'd6 : 3'($urandom_range(0, 7));
            misc_plane    = ($urandom_range(0, 9) == 0);
            opcode_sel    = 1'($urandom);
            cond_var_sel  = 2'($urandom);
            bus           = $urandom;
            opword_opcode = 6'($urandom);
            mlu_zero      = 1'($urandom);
            mlu_carry     = 1'($urandom);
            mlu_negative  = 1'($urandom);
            interrupt     = ($urandom_range(0, 3) == 0) ? ~interrupt : interrupt;
            n_booted      = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) begin
                n_rst = 1'b0;
                model_reset();
                #2;
                chk("rand_async_reset", int'(addr), 0);
                cyc();
                n_rst = 1'b1;
            end
            cyc();
        end

        // Only reset clears the sticky flag
        idle_inputs();
        n_rst = 1'b0;
        model_reset();
        #2;
        chk("final_reset_ovf", int'(overflow), 0);
        chk("final_reset_addr", int'(addr), 0);
        cyc();
        n_rst = 1'b1;
        cyc();
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
